// File: rtl/cache_req_fifo_pkg.sv
// Shared types for the data-cache request path.
package cache_pkg;
  localparam int STALL_CNT_W = 16;
  localparam int CACHE_AW    = 32;
  localparam int CACHE_DW    = 32;

  typedef struct packed {
    logic                we;
    logic [CACHE_AW-1:0] address;
    logic [CACHE_DW-1:0] data;
  } cache_req_t;
endpackage

// File: rtl/cache_req_fifo_if.sv
// Request (pipeline -> buffer) and head (buffer -> cache core) handshakes.
interface cache_req_fifo_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [AW-1:0] req_address_i;
  logic [DW-1:0] req_data_i;
  logic          cache_valid_o;
  logic          cache_ready_i;
  logic          cache_we_o;
  logic [AW-1:0] cache_address_o;
  logic [DW-1:0] cache_data_o;

  modport slave (
    input  req_valid_i, req_we_i, req_address_i, req_data_i, cache_ready_i,
    output req_ready_o, cache_valid_o, cache_we_o, cache_address_o, cache_data_o
  );
  modport master (
    output req_valid_i, req_we_i, req_address_i, req_data_i, cache_ready_i,
    input  req_ready_o, cache_valid_o, cache_we_o, cache_address_o, cache_data_o
  );
endinterface

// File: rtl/cache_req_fifo_storage.sv
// DEPTH-entry request register array: one write port, one muxed read port.
module cache_req_storage
  import cache_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = cache_req_t,
  parameter int  PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  T              wdata_i,
  input  logic [PW-1:0] raddr_i,
  output T              rdata_o
);
  T mem [DEPTH];

  // Contents are intentionally not reset; occupancy lives in the top.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++)
      if (we_i && waddr_i == PW'(i)) mem[i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/cache_req_fifo.sv
// Data-cache request FIFO with back-pressure, flush and saturating stall counter.
// Define CACHE_REQ_FIFO_BYPASS_EN for a zero-latency path when the buffer is empty.
module cache_req_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = CACHE_AW,
  parameter int DW    = CACHE_DW,
  parameter int CW    = $clog2(DEPTH+1),
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  cache_req_fifo_if.slave        bus,
  output logic [CW-1:0]          count_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  typedef struct packed {
    logic          we;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
  } req_t;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_valid;
  req_t          in_req, head, out_req;

  assign in_req     = '{we: bus.req_we_i, address: bus.req_address_i, data: bus.req_data_i};
  assign fifo_valid = (count != '0);
  assign bus.req_ready_o = (count < FULL);
  assign pop        = fifo_valid & bus.cache_ready_i;

`ifdef CACHE_REQ_FIFO_BYPASS_EN
  logic byp;
  assign byp  = ~fifo_valid & bus.req_valid_i;
  // A bypassed request taken by the cache this cycle never enters the array.
  assign push = bus.req_valid_i & bus.req_ready_o & ~(byp & bus.cache_ready_i);
  always_comb begin
    out_req           = '0;
    bus.cache_valid_o = fifo_valid | byp;
    if (fifo_valid)  out_req = head;
    else if (byp)    out_req = in_req;
  end
`else
  assign push = bus.req_valid_i & bus.req_ready_o;
  always_comb begin
    out_req           = '0;
    bus.cache_valid_o = fifo_valid;
    if (fifo_valid) out_req = head;
  end
`endif

  assign bus.cache_we_o      = out_req.we;
  assign bus.cache_address_o = out_req.address;
  assign bus.cache_data_o    = out_req.data;
  assign count_o             = count;

  cache_req_storage #(.DEPTH(DEPTH), .T(req_t), .PW(PW)) u_storage (
    .clk_i   (clk_i),
    .we_i    (push & ~flush_i),
    .waddr_i (wr_ptr),
    .wdata_i (in_req),
    .raddr_i (rd_ptr),
    .rdata_o (head)
  );

  // Flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stall_cnt_o <= '0;
    else if (bus.cache_valid_o && !bus.cache_ready_i && stall_cnt_o != '1)
      stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
  end
endmodule

// File: tb/tb_cache_req_fifo.sv
// Directed bench for cache_req_fifo (DEPTH=2); follows CACHE_REQ_FIFO_BYPASS_EN when defined.
module tb_cache_req_fifo;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  count;
  logic [15:0] stall_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  cache_req_fifo_if #(.AW(32), .DW(32)) bus ();

  cache_req_fifo #(.DEPTH(2), .AW(32), .DW(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .bus         (bus),
    .count_o     (count),
    .stall_cnt_o (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid_i   = v;
    bus.req_we_i      = we;
    bus.req_address_i = a;
    bus.req_data_i    = d;
  endtask

  initial begin
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    bus.cache_ready_i = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(bus.cache_valid_o), 64'd0);
    chk("rst_ready", 64'(bus.req_ready_o), 64'd1);
    tick();
    rst_ni = 1'b1;
    tick();

    // Ordering and back-pressure
    offer(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    tick();
    chk("A_count", 64'(count), 64'd1);
    chk("A_head", 64'(bus.cache_address_o), 64'h1000);
    offer(1'b1, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF);
    tick();
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("full_count", 64'(count), 64'd2);
    chk("full_ready", 64'(bus.req_ready_o), 64'd0);
    tick();
    chk("hold_head", 64'(bus.cache_address_o), 64'h1000);
    chk("hold_we", 64'(bus.cache_we_o), 64'd0);
    chk("stall_2", 64'(stall_cnt), 64'd2);
    bus.cache_ready_i = 1'b1;
    tick();
    chk("B_addr", 64'(bus.cache_address_o), 64'h2004);
    chk("B_we", 64'(bus.cache_we_o), 64'd1);
    chk("B_data", 64'(bus.cache_data_o), 64'hDEAD_BEEF);
    tick();
    chk("drain_valid", 64'(bus.cache_valid_o), 64'd0);
    chk("drain_addr", 64'(bus.cache_address_o), 64'd0);
    bus.cache_ready_i = 1'b0;

    // Full with a simultaneous offer: pop only, offer accepted next cycle
    offer(1'b1, 1'b0, 32'h0000_5000, 32'h0);
    tick();
    offer(1'b1, 1'b0, 32'h0000_6000, 32'h0);
    tick();
    offer(1'b1, 1'b0, 32'h0000_7000, 32'h0);
    bus.cache_ready_i = 1'b1;
    #1;
    chk("fo_ready", 64'(bus.req_ready_o), 64'd0);
    tick();
    chk("fo_count", 64'(count), 64'd1);
    chk("fo_head", 64'(bus.cache_address_o), 64'h6000);
    tick();
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    bus.cache_ready_i = 1'b0;
    #1;
    chk("fo_accept_cnt", 64'(count), 64'd1);
    chk("fo_accept_head", 64'(bus.cache_address_o), 64'h7000);
    tick();
    chk("stall_4", 64'(stall_cnt), 64'd4);

    // Flush beats push and pop
    flush = 1'b1;
    offer(1'b1, 1'b0, 32'h0000_3000, 32'h0);
    bus.cache_ready_i = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(bus.cache_valid_o), 64'd0);
    tick();
    chk("fl_addr", 64'(bus.cache_address_o), 64'd0);
    chk("fl_stall", 64'(stall_cnt), 64'd4);

    // Asynchronous reset with two entries queued
    bus.cache_ready_i = 1'b0;
    offer(1'b1, 1'b0, 32'h0000_8000, 32'h0);
    tick();
    offer(1'b1, 1'b0, 32'h0000_9000, 32'h0);
    tick();
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("pre_rst_count", 64'(count), 64'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_valid", 64'(bus.cache_valid_o), 64'd0);
    chk("mrst_addr", 64'(bus.cache_address_o), 64'd0);
    chk("mrst_ready", 64'(bus.req_ready_o), 64'd1);
    chk("mrst_stall", 64'(stall_cnt), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post_rst_valid", 64'(bus.cache_valid_o), 64'd0);

    // Empty buffer, push with cache ready
    bus.cache_ready_i = 1'b1;
    offer(1'b1, 1'b0, 32'h0000_4000, 32'h0);
    #1;
`ifdef CACHE_REQ_FIFO_BYPASS_EN
    chk("byp_valid", 64'(bus.cache_valid_o), 64'd1);
    chk("byp_addr", 64'(bus.cache_address_o), 64'h4000);
    tick();
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("byp_count", 64'(count), 64'd0);
    chk("byp_after", 64'(bus.cache_valid_o), 64'd0);
`else
    chk("reg_valid0", 64'(bus.cache_valid_o), 64'd0);
    chk("reg_addr0", 64'(bus.cache_address_o), 64'd0);
    tick();
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("reg_count", 64'(count), 64'd1);
    chk("reg_addr1", 64'(bus.cache_address_o), 64'h4000);
    tick();
    chk("reg_drain", 64'(count), 64'd0);
`endif

    // Stall counter saturation
    bus.cache_ready_i = 1'b0;
    offer(1'b1, 1'b0, 32'h0000_A000, 32'h0);
    tick();
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat", 64'(stall_cnt), 64'hFFFF);
    repeat (5) tick();
    chk("sat_hold", 64'(stall_cnt), 64'hFFFF);
    chk("sat_head", 64'(bus.cache_address_o), 64'hA000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
